// File: rtl/ram_stream_reader.sv
// Read-side master for a one-cycle-latency synchronous RAM: streams num_words_i words from start_addr_i on valid/ready.
// Defining RAM_READER_LAST_EN adds a last_o output flagging the final word of a transfer.
//
// state | meaning
// IDLE  | waiting for start_i
// READ  | issuing reads while streaming buffered words out
// DRAIN | every read issued, emptying the fifo

module ram_stream_reader #(
   parameter int width_p = 8,
   parameter int depth_p = 128
) (
   input  logic                       clk_i,
   input  logic                       reset_ni,
   input  logic                       start_i,
   input  logic [$clog2(depth_p)-1:0] start_addr_i,
   input  logic [$clog2(depth_p):0]   num_words_i,
   output logic                       busy_o,
   output logic                       done_o,
   output logic [$clog2(depth_p)-1:0] rd_addr_o,
   input  logic [width_p-1:0]         rd_data_i,
   output logic                       valid_o,
   output logic [width_p-1:0]         data_o,
`ifdef RAM_READER_LAST_EN
   output logic                       last_o,
   input  logic                       ready_i
`else
   input  logic                       ready_i
`endif
);

   localparam int AW = $clog2(depth_p);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_DRAIN
   } state_t;

   state_t              state_q, state_d;
   logic [AW-1:0]       rd_addr_q;
   logic [CW-1:0]       issue_cnt_q;
   logic [CW-1:0]       out_cnt_q;
   logic                inflight_q;
   logic                done_q, done_d;
   logic [width_p-1:0]  fifo_mem_q [2];
   logic                wr_ptr_q, rd_ptr_q;
   logic [1:0]          fifo_cnt_q;

   logic                push, pop, issue, start_ok;
   logic [2:0]          occ;
   logic [AW-1:0]       addr_next;

   assign push      = inflight_q;
   assign valid_o   = (fifo_cnt_q != 2'd0);
   assign pop       = valid_o && ready_i;
   assign data_o    = fifo_mem_q[rd_ptr_q];
   assign busy_o    = (state_q != ST_IDLE);
   assign done_o    = done_q;
   assign rd_addr_o = rd_addr_q;
   assign start_ok  = start_i && (num_words_i != '0);

   // slots already committed: outstanding read plus buffered words, less the one leaving now
   assign occ       = 3'(inflight_q) + 3'(fifo_cnt_q) - 3'(pop);
   assign addr_next = (rd_addr_q == AW'(depth_p - 1)) ? '0 : rd_addr_q + AW'(1);

`ifdef RAM_READER_LAST_EN
   assign last_o = valid_o && (out_cnt_q == CW'(1));
`endif

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      issue   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               state_d = ST_READ;
            end else if (start_i) begin
               done_d = 1'b1;
            end
         end
         ST_READ: begin
            issue = (occ < 3'd2);
            if (issue && issue_cnt_q == CW'(1)) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (pop && out_cnt_q == CW'(1)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q       <= ST_IDLE;
         rd_addr_q     <= '0;
         issue_cnt_q   <= '0;
         out_cnt_q     <= '0;
         inflight_q    <= 1'b0;
         done_q        <= 1'b0;
         fifo_mem_q[0] <= '0;
         fifo_mem_q[1] <= '0;
         wr_ptr_q      <= 1'b0;
         rd_ptr_q      <= 1'b0;
         fifo_cnt_q    <= 2'd0;
      end else begin
         state_q    <= state_d;
         done_q     <= done_d;
         inflight_q <= issue;
         if (state_q == ST_IDLE && start_ok) begin
            rd_addr_q   <= start_addr_i;
            issue_cnt_q <= num_words_i;
            out_cnt_q   <= num_words_i;
         end else begin
            if (issue) begin
               rd_addr_q   <= addr_next;
               issue_cnt_q <= issue_cnt_q - CW'(1);
            end
            if (pop) begin
               out_cnt_q <= out_cnt_q - CW'(1);
            end
         end
         if (push) begin
            fifo_mem_q[wr_ptr_q] <= rd_data_i;
            wr_ptr_q             <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         fifo_cnt_q <= fifo_cnt_q + 2'(push) - 2'(pop);
      end
   end

endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Read-side master for a 1R1W synchronous RAM with one-cycle read latency, as used for frame and line storage in the Sobel pipeline.
- On a start command, reads num_words_i consecutive words beginning at start_addr_i.
- Address wraps modulo depth_p.
- Emits the words in order on a valid/ready stream toward the filter datapath, with full backpressure support and no lost reads.

Parameters:
- width_p, 8: data word width; must match the RAM width.
- depth_p, 128: RAM depth; address width is $clog2(depth_p).

Ports:
- clk_i  input  1  single clock; all logic on its rising edge.
- reset_ni  input  1  synchronous, active-low reset.
- start_i  input  1  start command; sampled only in IDLE.
- start_addr_i  input  $clog2(depth_p)  first address; latched on start.
- num_words_i  input  $clog2(depth_p)+1  word count, 0..depth_p; latched on start.
- busy_o  output  1  transfer in progress.
- done_o  output  1  one-cycle pulse at transfer completion.
- rd_addr_o  output  $clog2(depth_p)  RAM read address (registered).
- rd_data_i  input  width_p  RAM read data; equals mem[rd_addr_o of the previous cycle].
- valid_o  output  1  data_o holds a word.
- data_o  output  width_p  stream data.
- ready_i  input  1  downstream accept; a transfer occurs when valid_o and ready_i are both high.

Behaviour:
- Reset (reset_ni=0 at an edge):
  - state=IDLE; busy_o=0, done_o=0, valid_o=0, rd_addr_o=0, data_o=0.
  - FIFO emptied; in-flight and word counters cleared.
  - Applies mid-transfer: all buffered and in-flight data is discarded, and done_o does not pulse.
- FSM states: IDLE, READ, DRAIN.
  - IDLE -> READ: start_i=1 and num_words_i!=0. Latch addr=start_addr_i, issue_cnt=num_words_i, out_cnt=num_words_i.
  - IDLE, start_i=1 and num_words_i=0: stay IDLE, no reads issued, done_o=1 next cycle.
  - READ -> DRAIN: when the last read is issued (issue_cnt goes 1->0).
  - DRAIN -> IDLE: when the last word is accepted (out_cnt goes 1->0). done_o=1 in the following cycle.
  - start_i is ignored outside IDLE.
- busy_o=1 exactly while state is READ or DRAIN.
- Read issue:
  - Internal fifo is 2 entries deep.
  - A read is issued in a READ cycle when inflight + fifo_count - pop < 2. Here pop = valid_o & ready_i in the same cycle, and inflight is 0 or 1.
  - An issued read presents addr on rd_addr_o in that cycle. rd_data_i is valid in the next cycle and is pushed into the fifo at the end of that cycle.
  - After each issue: addr increments; depth_p-1 wraps to 0 (for non-power-of-2 depth_p, compare explicitly); issue_cnt decrements.
  - rd_addr_o holds its value when no read is issued.
- Output:
  - valid_o = fifo non-empty; data_o = fifo head.
  - data_o stays stable while valid_o=1 and ready_i=0.
  - Push and pop in the same cycle are legal; count is unchanged.
  - Words leave in address order, with no duplication or loss.
- Latency and throughput:
  - start_i high in cycle c0 -> first read issued in c1 -> valid_o=1 with mem[start_addr] in c3.
  - With ready_i held high: one word per cycle sustained; last word in cycle c(2+N); done_o in c(3+N).
- Backpressure: with ready_i=0, at most 2 words are buffered and no further reads issue. Issuing resumes in the same cycle that a pop occurs.
- Full transfer: num_words_i=depth_p reads every location exactly once, starting at start_addr_i and wrapping.

Optional Feature:
- RAM_READER_LAST_EN
- Defined: adds output port last_o (1 bit). last_o=1 when valid_o=1 and the head word is the final word of the transfer (out_cnt==1). last_o=0 at reset and otherwise.
- Undefined: port absent; no added logic; all other behaviour identical.

Test Plan:
- RAM preloaded mem[i]=i; start_addr=5, num=4, ready_i=1 -> data 5,6,7,8 in cycles c3..c6; done_o pulse in c7; busy_o high c1..c6.
- start_addr=126, num=4, depth_p=128 -> rd_addr_o sequence 126,127,0,1; data 126,127,0,1.
- num=6, ready_i toggling 1,0,0,1,... -> exactly 6 words in order. fifo never exceeds 2 entries; data_o stable while stalled.
- num=0 -> no read issued, valid_o stays 0, done_o=1 one cycle after start; busy_o stays 0.
- Reset pulsed (reset_ni=0) at c4 of a 10-word transfer -> next cycle valid_o=0, busy_o=0, no done_o. A new start afterward completes correctly.
- RAM_READER_LAST_EN defined, num=3 -> last_o=1 only on the beat carrying the third word. start_i pulsed while busy is ignored: no change to count or address.
